stream_rr_fifo_mux: RTL and testbench

//  Merges NUM_CH parametrised valid/ready streams into one buffered output stream.

---
 rtl/stream_pkg.sv | 8 +
 rtl/stream_if.sv | 12 +
 rtl/stream_fifo.sv | 46 ++++
 rtl/stream_rr_fifo_mux.sv | 65 ++++++
 tb/tb_stream_rr_fifo_mux.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/stream_pkg.sv
// stream_pkg: shared constants and width helpers for the stream merge block
package stream_pkg;
  localparam int STREAM_DEF_WIDTH = 8;
  localparam int STREAM_DEF_DEPTH = 8;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stream_if.sv
// stream_if: valid/ready/data bundle for binding one stream endpoint
interface stream_if #(
  parameter int WIDTH = 8
) (
  input logic clk
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  modport src(input clk, output valid, output data, input ready);
  modport snk(input clk, input valid, input data, output ready);
endinterface

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous FIFO with occupancy count; output reads zero when empty
module stream_fifo
  import stream_pkg::*;
#(
  parameter int WIDTH = STREAM_DEF_WIDTH,
  parameter int DEPTH = STREAM_DEF_DEPTH,
  localparam int CNT_W = clog2_min1(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = clog2_min1(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [CNT_W-1:0] r_count;
  logic             w_push, w_pop;
  assign o_full  = r_count == CNT_W'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rd];
  // pointers wrap at DEPTH-1 so non-power-of-2 depths work; reset drops all words
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == PTR_W'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop) r_rd <= (r_rd == PTR_W'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
  // storage is never read before being written, so it carries no reset
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/stream_rr_fifo_mux.sv
// stream_rr_fifo_mux: round-robin merge of NUM_CH streams into one tagged, buffered stream
module stream_rr_fifo_mux
  import stream_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = STREAM_DEF_WIDTH,
  parameter int DEPTH  = STREAM_DEF_DEPTH,
  localparam int CH_W  = clog2_min1(NUM_CH),
  localparam int CNT_W = clog2_min1(DEPTH + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_CH-1:0]       i_valid,
  input  logic [NUM_CH*WIDTH-1:0] i_data,
  output logic [NUM_CH-1:0]       o_ready,
  output logic                    o_valid,
  output logic [WIDTH-1:0]        o_data,
  output logic [CH_W-1:0]         o_ch,
  input  logic                    i_ready,
  output logic [CNT_W-1:0]        o_count,
  output logic                    o_full
);
  if (NUM_CH < 1 || WIDTH < 1 || DEPTH < 2) begin : g_bad_params
    $error("stream_rr_fifo_mux: need NUM_CH>=1, WIDTH>=1, DEPTH>=2");
  end
  logic [CH_W-1:0]       r_rr, w_gidx;
  logic                  w_any, w_push, w_empty;
  logic [WIDTH-1:0]      w_wdata;
  logic [CH_W+WIDTH-1:0] w_head;
  // scan channels from r_rr upward with wrap; the first valid one wins the grant
  always_comb begin
    w_any   = 1'b0;
    w_gidx  = '0;
    w_wdata = '0;
    for (int k = 0; k < NUM_CH; k++)
      for (int c = 0; c < NUM_CH; c++)
        if (!w_any && i_valid[c] && c == (int'(r_rr) + k) % NUM_CH) begin
          w_any   = 1'b1;
          w_gidx  = CH_W'(c);
          w_wdata = i_data[c*WIDTH +: WIDTH];
        end
  end
  // ready ignores i_ready on purpose: a full FIFO blocks pushes even while popping
  assign o_ready = {NUM_CH{w_any & ~o_full & i_rst_n}} & (NUM_CH'(1) << w_gidx);
  assign w_push  = |(i_valid & o_ready);
  assign o_valid = ~w_empty;
  assign {o_ch, o_data} = w_head;
  // priority moves to the channel after the one just served
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_rr <= '0;
    else if (w_push) r_rr <= (w_gidx == CH_W'(NUM_CH - 1)) ? '0 : w_gidx + 1'b1;
  end
  stream_fifo #(.WIDTH(CH_W + WIDTH), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  ({w_gidx, w_wdata}),
    .i_pop   (i_ready),
    .o_data  (w_head),
    .o_count (o_count),
    .o_full  (o_full),
    .o_empty (w_empty)
  );
  a_ready_onehot0: assert property (@(posedge i_clk) $onehot0(o_ready));
endmodule

// File: tb/tb_stream_rr_fifo_mux.sv
// tb_stream_rr_fifo_mux: directed checks of arbitration, buffering, wrap and reset
module tb_stream_rr_fifo_mux;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  valid = 4'hF;
  logic [31:0] data = '0;
  logic [3:0]  o_ready;
  logic [1:0]  o_ch;
  logic [3:0]  o_count;
  logic        o_full;
  logic [3:0]  vb = '0;
  logic [31:0] db = '0;
  logic        rdyb = 1'b0;
  logic [3:0]  orb;
  logic        ovb;
  logic [7:0]  odb;
  logic [1:0]  ochb;
  logic [2:0]  ocb;
  logic        ofb;
  int          vecs = 0;
  int          errs = 0;
  stream_if #(.WIDTH(8)) out_if (.clk(clk));
  always #5 clk = ~clk;
  stream_rr_fifo_mux dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .o_ready(o_ready),
    .o_valid(out_if.valid), .o_data(out_if.data), .o_ch(o_ch), .i_ready(out_if.ready),
    .o_count(o_count), .o_full(o_full)
  );
  stream_rr_fifo_mux #(.NUM_CH(4), .WIDTH(8), .DEPTH(5)) dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vb), .i_data(db), .o_ready(orb),
    .o_valid(ovb), .o_data(odb), .o_ch(ochb), .i_ready(rdyb),
    .o_count(ocb), .o_full(ofb)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    out_if.ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vecs++; if (o_ready !== 4'b0) begin errs++; $display("FAIL reset_ready: got %b want 0000", o_ready); end
      vecs++; if (out_if.valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", out_if.valid); end
      vecs++; if (o_count !== 4'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", o_count); end
    end
    rst_n = 1'b1;
    #1;
    vecs++; if (o_ready !== 4'b0001) begin errs++; $display("FAIL release_ready: got %b want 0001", o_ready); end
    valid = 4'h0;
    tick();
  endtask
  task automatic test_round_robin;
    valid = 4'hF;
    data = 32'h33221100;
    out_if.ready = 1'b1;
    #1;
    vecs++; if (o_ready !== 4'b0001) begin errs++; $display("FAIL rr_first_ready: got %b want 0001", o_ready); end
    tick();
    for (int i = 0; i < 8; i++) begin
      vecs++; if (o_ch !== 2'(i % 4)) begin errs++; $display("FAIL rr_ch[%0d]: got %0d want %0d", i, o_ch, i % 4); end
      vecs++; if (out_if.data !== 8'((i % 4) * 8'h11)) begin errs++; $display("FAIL rr_data[%0d]: got %h want %h", i, out_if.data, (i % 4) * 8'h11); end
      vecs++; if (o_count !== 4'd1) begin errs++; $display("FAIL rr_count[%0d]: got %0d want 1", i, o_count); end
      tick();
    end
    valid = 4'h0;
    #1;
    vecs++; if (o_ch !== 2'd0 || out_if.data !== 8'h00) begin errs++; $display("FAIL rr_tail: got ch %0d data %h want ch 0 data 00", o_ch, out_if.data); end
    tick();
    vecs++; if (out_if.valid !== 1'b0) begin errs++; $display("FAIL rr_drained: got %b want 0", out_if.valid); end
  endtask
  task automatic test_fill_full;
    out_if.ready = 1'b0;
    valid = 4'b0100;
    for (int k = 1; k <= 8; k++) begin
      data = 32'(k) << 16;
      #1;
      vecs++; if (o_ready !== 4'b0100) begin errs++; $display("FAIL fill_ready[%0d]: got %b want 0100", k, o_ready); end
      tick();
    end
    vecs++; if (o_count !== 4'd8) begin errs++; $display("FAIL fill_count: got %0d want 8", o_count); end
    vecs++; if (o_full !== 1'b1) begin errs++; $display("FAIL fill_full: got %b want 1", o_full); end
    vecs++; if (o_ready !== 4'b0) begin errs++; $display("FAIL fill_blocked: got %b want 0000", o_ready); end
    valid = 4'h0;
    out_if.ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      #1;
      vecs++; if (out_if.valid !== 1'b1 || out_if.data !== 8'(k) || o_ch !== 2'd2) begin errs++; $display("FAIL drain[%0d]: got v%b %h ch%0d want v1 %h ch2", k, out_if.valid, out_if.data, o_ch, k); end
      tick();
    end
    vecs++; if (out_if.valid !== 1'b0 || o_count !== 4'd0 || out_if.data !== 8'h00 || o_ch !== 2'd0) begin errs++; $display("FAIL drain_empty: got v%b cnt%0d %h ch%0d want v0 cnt0 00 ch0", out_if.valid, o_count, out_if.data, o_ch); end
  endtask
  task automatic test_full_pop;
    out_if.ready = 1'b0;
    valid = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      data = 32'(8'h10 + k) << 8;
      tick();
    end
    data = 32'h18 << 8;
    out_if.ready = 1'b1;
    #1;
    vecs++; if (o_full !== 1'b1 || o_ready !== 4'b0) begin errs++; $display("FAIL fullpop_block: got full %b ready %b want 1 0000", o_full, o_ready); end
    tick();
    vecs++; if (o_count !== 4'd7 || o_ready !== 4'b0010) begin errs++; $display("FAIL fullpop_pop_only: got cnt %0d ready %b want 7 0010", o_count, o_ready); end
    vecs++; if (out_if.data !== 8'h11) begin errs++; $display("FAIL fullpop_head1: got %h want 11", out_if.data); end
    tick();
    vecs++; if (o_count !== 4'd7 || out_if.data !== 8'h12) begin errs++; $display("FAIL fullpop_both: got cnt %0d %h want 7 12", o_count, out_if.data); end
    valid = 4'h0;
    for (int k = 0; k < 7; k++) begin
      #1;
      vecs++; if (out_if.data !== 8'(8'h12 + k) || o_ch !== 2'd1) begin errs++; $display("FAIL fullpop_drain[%0d]: got %h ch%0d want %h ch1", k, out_if.data, o_ch, 8'h12 + k); end
      tick();
    end
    vecs++; if (out_if.valid !== 1'b0) begin errs++; $display("FAIL fullpop_empty: got %b want 0", out_if.valid); end
  endtask
  task automatic test_wrap;
    logic [7:0] q[$];
    int sent = 0;
    int got = 0;
    int cyc = 0;
    bit exp_push, exp_pop;
    while (got < 13 && cyc < 80) begin
      vb = (sent < 13) ? 4'b1000 : 4'b0000;
      db = 32'(sent) << 24;
      rdyb = (cyc % 3) != 0;
      #1;
      exp_push = sent < 13 && q.size() < 5;
      exp_pop = rdyb && q.size() > 0;
      vecs++; if (orb !== (exp_push ? 4'b1000 : 4'b0000)) begin errs++; $display("FAIL wrap_ready[%0d]: got %b want %b", cyc, orb, exp_push ? 4'b1000 : 4'b0000); end
      vecs++; if (ocb !== 3'(q.size())) begin errs++; $display("FAIL wrap_count[%0d]: got %0d want %0d", cyc, ocb, q.size()); end
      vecs++; if (ovb !== (q.size() != 0)) begin errs++; $display("FAIL wrap_valid[%0d]: got %b want %b", cyc, ovb, q.size() != 0); end
      if (q.size() != 0) begin
        vecs++; if (odb !== q[0] || ochb !== 2'd3) begin errs++; $display("FAIL wrap_data[%0d]: got %h ch%0d want %h ch3", cyc, odb, ochb, q[0]); end
      end
      if (exp_pop) begin
        void'(q.pop_front());
        got++;
      end
      if (exp_push) begin
        q.push_back(8'(sent));
        sent++;
      end
      tick();
      cyc++;
    end
    vecs++; if (got != 13) begin errs++; $display("FAIL wrap_timeout: got %0d words want 13", got); end
    vb = 4'h0;
    rdyb = 1'b0;
  endtask
  task automatic test_reset_mid;
    out_if.ready = 1'b0;
    valid = 4'b0111;
    data = 32'h00CCBBAA;
    repeat (3) tick();
    vecs++; if (o_count !== 4'd3) begin errs++; $display("FAIL mid_count3: got %0d want 3", o_count); end
    rst_n = 1'b0;
    valid = 4'hF;
    out_if.ready = 1'b1;
    #1;
    vecs++; if (o_ready !== 4'b0) begin errs++; $display("FAIL mid_ready_low: got %b want 0000", o_ready); end
    tick();
    rst_n = 1'b1;
    #1;
    vecs++; if (out_if.valid !== 1'b0 || o_count !== 4'd0 || out_if.data !== 8'h00) begin errs++; $display("FAIL mid_cleared: got v%b cnt%0d %h want v0 cnt0 00", out_if.valid, o_count, out_if.data); end
    vecs++; if (o_ready !== 4'b0001) begin errs++; $display("FAIL mid_rr_reset: got %b want 0001", o_ready); end
    valid = 4'b0001;
    data = 32'h5A;
    tick();
    valid = 4'h0;
    #1;
    vecs++; if (out_if.data !== 8'h5A || o_ch !== 2'd0 || o_count !== 4'd1) begin errs++; $display("FAIL mid_new_word: got %h ch%0d cnt%0d want 5a ch0 cnt1", out_if.data, o_ch, o_count); end
    tick();
    vecs++; if (out_if.valid !== 1'b0) begin errs++; $display("FAIL mid_no_stale: got %b want 0", out_if.valid); end
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_fill_full();
    test_full_pop();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
